// File: rtl/truth_table_unit.sv
// Programmable N-input Boolean function: a 2^N-bit truth table loaded serially,
// then evaluated per request or swept exhaustively to count its minterms.
module truth_table_unit #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_start,
  input  logic         load_valid,
  input  logic         load_bit,
  output logic         load_ready,
  output logic         table_valid,
  input  logic         eval_valid,
  input  logic [N-1:0] eval_in,
  input  logic         sweep_start,
  output logic         busy,
  output logic         y,
  output logic         y_valid,
  output logic [N-1:0] y_idx,
  output logic         sweep_done,
  output logic [N:0]   minterm_count
);
  localparam int DEPTH = 1 << N;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SWEEP} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [DEPTH-1:0]   r_table;
  logic [N-1:0]       r_cnt;
  logic [N-1:0]       r_idx;
  logic [N:0]         r_acc;
  logic               r_table_valid;
  logic               r_y;
  logic               r_y_valid;
  logic [N-1:0]       r_y_idx;
  logic               r_sweep_done;
  logic [N:0]         r_count;
  logic               w_accept;
  logic               w_sweep_bit;

  assign w_accept    = (r_state == S_LOAD) && load_valid;
  assign w_sweep_bit = r_table[r_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (cfg_start)                         w_next = S_LOAD;
        else if (sweep_start && r_table_valid) w_next = S_SWEEP;
      end
      S_LOAD:  if (w_accept && (&r_cnt)) w_next = S_IDLE;
      S_SWEEP: if (&r_idx)               w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_table       <= '0;
      r_cnt         <= '0;
      r_idx         <= '0;
      r_acc         <= '0;
      r_table_valid <= 1'b0;
      r_y           <= 1'b0;
      r_y_valid     <= 1'b0;
      r_y_idx       <= '0;
      r_sweep_done  <= 1'b0;
      r_count       <= '0;
    end else begin
      r_y_valid    <= 1'b0;
      r_sweep_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_table_valid <= 1'b0;
            r_cnt         <= '0;
          end else if (sweep_start && r_table_valid) begin
            r_idx <= '0;
            r_acc <= '0;
          end else if (eval_valid && r_table_valid) begin
            r_y       <= r_table[eval_in];
            r_y_idx   <= eval_in;
            r_y_valid <= 1'b1;
          end
        end
        S_LOAD: begin
          if (w_accept) begin
            r_table[r_cnt] <= load_bit;
            r_cnt          <= r_cnt + N'(1);
            if (&r_cnt) r_table_valid <= 1'b1;
          end
        end
        S_SWEEP: begin
          // Index wraps to 0 naturally on the final step, which is also the exit.
          r_y       <= w_sweep_bit;
          r_y_idx   <= r_idx;
          r_y_valid <= 1'b1;
          r_acc     <= r_acc + (N+1)'(w_sweep_bit);
          r_idx     <= r_idx + N'(1);
          if (&r_idx) begin
            r_count      <= r_acc + (N+1)'(w_sweep_bit);
            r_sweep_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_ready    = (r_state == S_LOAD);
  assign busy          = (r_state != S_IDLE);
  assign table_valid   = r_table_valid;
  assign y             = r_y;
  assign y_valid       = r_y_valid;
  assign y_idx         = r_y_idx;
  assign sweep_done    = r_sweep_done;
  assign minterm_count = r_count;
endmodule
